multi_lap_timer: RTL

MULTI_LAP_TIMER -- requirements
Module: multi_lap_timer

---
 rtl/race_pkg.sv | 21 ++
 rtl/tick_gen.sv | 32 +++
 rtl/multi_lap_timer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/race_pkg.sv
// race_pkg -- shared definitions for the multi-player lap timer.
//   state_t    : race FSM encoding (IDLE, RUNNING, PAUSED, FINISHED)
//   LAP_W      : width of each per-player lap counter
//   best_none(): all-ones "no lap recorded yet" value for a time field
//                of the given width (1..32 bits)
package race_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    PAUSED   = 2'd2,
    FINISHED = 2'd3
  } state_t;

  localparam int unsigned LAP_W = 8;

  function automatic logic [31:0] best_none(input int unsigned width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen -- free-running prescaler that divides pclk into timing ticks.
//   pclk : clock
//   rst  : synchronous active-high clear (count back to 0)
//   en   : count only while high; the count holds while low
//   tick : single-cycle pulse while the count sits at DIV-1; the count
//          wraps to 0 on the following edge
module tick_gen #(
  parameter int unsigned DIV = 400000
) (
  input  logic pclk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick = en && (count == CNT_W'(DIV - 1));

  // NOTE: clocked state is written with non-blocking (<=) so every flop
  // samples pre-edge values; blocking here would create simulation races.
  always_ff @(posedge pclk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_lap_timer.sv
// multi_lap_timer -- lap timer for N_PLAYERS independent channels.
//   pclk, rst         : clock, synchronous active-high reset
//   start, stop       : race start/resume and pause requests (levels,
//                       rising edges act)
//   lap_finished      : per-player finish-line crossing (level, rising edge)
//   current_lap_time  : running lap time per player, TIME_W ticks each
//   last_lap_time     : last completed lap per player
//   best_lap_time     : best completed lap per player, all-ones = none yet
//   lap_count         : completed laps per player, LAP_W bits each
//   player_done       : player has completed N_LAPS laps
//   race_running      : race is in the RUNNING state
//   winner, winner_valid : first player to finish (lowest index on a tie)
// Player i occupies bits [i*W +: W] of every packed per-player output.
// TIME_W must be 1..32.
module multi_lap_timer import race_pkg::*; #(
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned TIME_W    = 16,
  parameter int unsigned TICK_DIV  = 400000,
  parameter int unsigned N_LAPS    = 3
) (
  input  logic                          pclk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic [N_PLAYERS-1:0]          lap_finished,
  output logic [N_PLAYERS*TIME_W-1:0]   current_lap_time,
  output logic [N_PLAYERS*TIME_W-1:0]   last_lap_time,
  output logic [N_PLAYERS*TIME_W-1:0]   best_lap_time,
  output logic [N_PLAYERS*LAP_W-1:0]    lap_count,
  output logic [N_PLAYERS-1:0]          player_done,
  output logic                          race_running,
  output logic [2:0]                    winner,
  output logic                          winner_valid
);

  localparam logic [TIME_W-1:0] BEST_NONE = TIME_W'(best_none(TIME_W));
  // Running times stop one below all-ones so they never alias BEST_NONE.
  localparam logic [TIME_W-1:0] CUR_MAX   = BEST_NONE - TIME_W'(1);

  state_t               state;
  logic                 start_q, stop_q;
  logic [N_PLAYERS-1:0] lap_q;
  logic                 start_edge, stop_edge;
  logic [N_PLAYERS-1:0] lap_edge;
  logic                 running;
  logic                 new_race;
  logic                 tick;
  logic [N_PLAYERS-1:0] set_done;
  logic [2:0]           winner_next;

  assign start_edge = start && !start_q;
  assign stop_edge  = stop  && !stop_q;
  assign lap_edge   = lap_finished & ~lap_q;
  assign running    = (state == RUNNING);
  // A start from IDLE or FINISHED begins a fresh race and wipes all results.
  assign new_race   = start_edge && ((state == IDLE) || (state == FINISHED));

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .pclk (pclk),
    .rst  (rst || new_race),
    .en   (running),
    .tick (tick)
  );

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_player
    logic [TIME_W-1:0] cur, last, best;
    logic [LAP_W-1:0]  cnt;
    logic              done;
    logic              lap_ok;

    assign lap_ok      = running && lap_edge[i] && !done;
    assign set_done[i] = lap_ok && (cnt == LAP_W'(N_LAPS - 1));

    // NOTE: these per-player registers are a handful of flops, not a RAM
    // array, so each one is reset explicitly to a known value.
    always_ff @(posedge pclk) begin
      if (rst || new_race) begin
        cur  <= '0;
        last <= '0;
        best <= BEST_NONE;
        cnt  <= '0;
        done <= 1'b0;
      end else if (lap_ok) begin
        // The completed lap is the pre-tick value; a coincident tick is
        // credited to the new lap.
        last <= cur;
        cnt  <= cnt + LAP_W'(1);
        if (cur < best) best <= cur;
        if (set_done[i]) begin
          done <= 1'b1;
          cur  <= '0;
        end else begin
          cur <= tick ? TIME_W'(1) : '0;
        end
      end else if (tick && !done && (cur != CUR_MAX)) begin
        cur <= cur + TIME_W'(1);
      end
    end

    assign current_lap_time[i*TIME_W +: TIME_W] = cur;
    assign last_lap_time[i*TIME_W +: TIME_W]    = last;
    assign best_lap_time[i*TIME_W +: TIME_W]    = best;
    assign lap_count[i*LAP_W +: LAP_W]          = cnt;
    assign player_done[i]                       = done;
  end

  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned and infers a latch.
  always_comb begin
    winner_next = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (set_done[i]) winner_next = 3'(i);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      lap_q        <= '0;
      race_running <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      lap_q   <= lap_finished;

      case (state)
        IDLE, FINISHED: begin
          if (start_edge) begin
            state        <= RUNNING;
            race_running <= 1'b1;
            winner       <= '0;
            winner_valid <= 1'b0;
          end
        end
        RUNNING: begin
          // Completing the race outranks a simultaneous pause request.
          if (&(player_done | set_done)) begin
            state        <= FINISHED;
            race_running <= 1'b0;
          end else if (stop_edge) begin
            state        <= PAUSED;
            race_running <= 1'b0;
          end
          if ((|set_done) && !winner_valid) begin
            winner       <= winner_next;
            winner_valid <= 1'b1;
          end
        end
        PAUSED: begin
          if (start_edge) begin
            state        <= RUNNING;
            race_running <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          race_running <= 1'b0;
        end
      endcase
    end
  end

endmodule
